// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order inst_sram reads, tracks in-flight PCs,
// drops responses made stale by redirects and buffers results for decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int          MAX_OUT  = 2,
  parameter int          IQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  input  logic        excp_flush,
  input  logic [31:0] eentry,
  input  logic        ertn_flush,
  input  logic [31:0] era,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata
);
  localparam int IQW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int IFW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW  = 5;
  localparam logic [CW-1:0]  MAX_OUT_C  = CW'(MAX_OUT);
  localparam logic [CW-1:0]  IQ_DEPTH_C = CW'(IQ_DEPTH);
  localparam logic [IFW-1:0] IF_LAST    = IFW'(MAX_OUT - 1);

  logic [31:0]    fpc_q, fpc_d;
  logic           halt_q, halt_d;
  logic           run_q;
  logic [CW-1:0]  outstanding_q, outstanding_d;
  logic [CW-1:0]  discard_q, discard_d;
  logic [64:0]    iq_q [IQ_DEPTH];
  logic [64:0]    iq_d [IQ_DEPTH];
  logic [IQW-1:0] iq_head_q, iq_head_d, iq_tail_q, iq_tail_d;
  logic [CW-1:0]  iq_count_q, iq_count_d;
  logic [31:0]    ifl_pc_q [MAX_OUT];
  logic [31:0]    ifl_pc_d [MAX_OUT];
  logic [IFW-1:0] ifl_rd_q, ifl_rd_d, ifl_wr_q, ifl_wr_d;

  logic        redirect, iq_room, fetch_ok, req_hs, adef_push, resp_keep;
  logic        iq_push, iq_pop;
  logic [31:0] redirect_pc;

  function automatic logic [IFW-1:0] ifl_next(input logic [IFW-1:0] p);
    return (p == IF_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    redirect = excp_flush | ertn_flush | br_taken;
    if (excp_flush)      redirect_pc = eentry;
    else if (ertn_flush) redirect_pc = era;
    else                 redirect_pc = br_target;

    // Queue credit counts requests already accepted so every response has a slot.
    iq_room        = (outstanding_q + iq_count_q) < IQ_DEPTH_C;
    fetch_ok       = run_q && !redirect && !halt_q;
    inst_sram_req  = fetch_ok && (fpc_q[1:0] == 2'b00) &&
                     ((outstanding_q + discard_q) < MAX_OUT_C) && iq_room;
    req_hs         = inst_sram_req && inst_sram_addr_ok;
    adef_push      = fetch_ok && (fpc_q[1:0] != 2'b00) && iq_room;
    resp_keep      = inst_sram_data_ok && (discard_q == '0) && !redirect;
    fs_to_ds_valid = (iq_count_q != '0) && !redirect;
    iq_pop         = fs_to_ds_valid && ds_allowin;
    iq_push        = resp_keep || adef_push;

    fpc_d         = fpc_q;
    halt_d        = halt_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    iq_d          = iq_q;
    iq_head_d     = iq_head_q;
    iq_tail_d     = iq_tail_q;
    iq_count_d    = iq_count_q;
    ifl_pc_d      = ifl_pc_q;
    ifl_rd_d      = ifl_rd_q;
    ifl_wr_d      = ifl_wr_q;

    if (iq_push)
      iq_d[iq_tail_q] = resp_keep ? {ifl_pc_q[ifl_rd_q], inst_sram_rdata, 1'b0}
                                  : {fpc_q, 32'h0, 1'b1};

    if (redirect) begin
      // Everything still in flight becomes a response to drop.
      fpc_d         = redirect_pc;
      halt_d        = 1'b0;
      iq_head_d     = '0;
      iq_tail_d     = '0;
      iq_count_d    = '0;
      outstanding_d = '0;
      discard_d     = discard_q + outstanding_q + CW'(req_hs) - CW'(inst_sram_data_ok);
    end else begin
      if (req_hs)    fpc_d  = fpc_q + 32'd4;
      if (adef_push) halt_d = 1'b1;
      outstanding_d = outstanding_q + CW'(req_hs) - CW'(resp_keep);
      if (inst_sram_data_ok && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (iq_push) iq_tail_d = iq_tail_q + 1'b1;
      if (iq_pop)  iq_head_d = iq_head_q + 1'b1;
      iq_count_d = iq_count_q + CW'(iq_push) - CW'(iq_pop);
    end

    if (req_hs) begin
      ifl_pc_d[ifl_wr_q] = fpc_q;
      ifl_wr_d           = ifl_next(ifl_wr_q);
    end
    if (inst_sram_data_ok) ifl_rd_d = ifl_next(ifl_rd_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q         <= RESET_PC;
      halt_q        <= 1'b0;
      run_q         <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
      iq_q          <= '{default: '0};
      iq_head_q     <= '0;
      iq_tail_q     <= '0;
      iq_count_q    <= '0;
      ifl_pc_q      <= '{default: '0};
      ifl_rd_q      <= '0;
      ifl_wr_q      <= '0;
    end else begin
      fpc_q         <= fpc_d;
      halt_q        <= halt_d;
      run_q         <= 1'b1;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      iq_q          <= iq_d;
      iq_head_q     <= iq_head_d;
      iq_tail_q     <= iq_tail_d;
      iq_count_q    <= iq_count_d;
      ifl_pc_q      <= ifl_pc_d;
      ifl_rd_q      <= ifl_rd_d;
      ifl_wr_q      <= ifl_wr_d;
    end
  end

  assign fs_to_ds_bus    = iq_q[iq_head_q];
  assign inst_sram_addr  = fpc_q;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

  // A response must always find a free queue slot and a tracked request.
  assert property (@(posedge clk) disable iff (reset)
    !(iq_push && !iq_pop && (iq_count_q == IQ_DEPTH_C)));
  assert property (@(posedge clk) disable iff (reset)
    !(inst_sram_data_ok && ((outstanding_q + discard_q) == '0)));
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with random latency, and an
// instruction-stream reference built from the redirect/sequential-PC rules.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h1c000000;
  localparam int MAX_OUT  = 2;
  localparam int IQ_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic        excp_flush, ertn_flush, br_taken;
  logic [31:0] eentry, era, br_target;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;

  fetch_unit #(.RESET_PC(RESET_PC), .MAX_OUT(MAX_OUT), .IQ_DEPTH(IQ_DEPTH)) dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .excp_flush(excp_flush), .eentry(eentry), .ertn_flush(ertn_flush), .era(era),
    .br_taken(br_taken), .br_target(br_target),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_wdata(inst_sram_wdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] mem_addr_q[$];
  int          mem_cyc_q[$];
  int          addr_pct, data_pct;
  bit          mem_hold;

  bit          r_allow, r_excp, r_ertn, r_br;
  logic [31:0] r_eentry, r_era, r_br_target;
  logic [2:0]  sel;

  logic [31:0] exp_pc, exp_req_pc;
  bit          exp_mis, exp_adef_done;
  int          n_hs, n_deliv;
  int          deliv_cyc[$];
  logic [31:0] deliv_pc[$];
  bit          last_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a3c96e1;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = {16'h1c00, 14'($urandom), 2'b00};
    if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    excp_flush = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0;
    r_excp = 1'b0; r_ertn = 1'b0; r_br = 1'b0;
    ds_allowin = 1'b1; inst_sram_addr_ok = 1'b1; inst_sram_data_ok = 1'b0;
    mem_addr_q.delete(); mem_cyc_q.delete();
    #1;
    check("rst_valid", 65'(fs_to_ds_valid), 65'(0));
    check("rst_req", 65'(inst_sram_req), 65'(0));
    check("rst_addr", 65'(inst_sram_addr), 65'(RESET_PC));
    check("const_bus", 65'({inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_wdata}),
          65'({1'b0, 2'b10, 4'h0, 32'h0}));
    @(posedge clk); #1;
    check("rst_req_held", 65'(inst_sram_req), 65'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("req_before_first_edge", 65'(inst_sram_req), 65'(0));
    exp_pc = RESET_PC; exp_req_pc = RESET_PC; exp_mis = 1'b0; exp_adef_done = 1'b0;
  endtask

  // One clock: drive at negedge, settle, check, advance memory and reference model.
  task automatic step();
    bit          redir;
    logic [31:0] tgt;
    logic [64:0] exp_bus;
    @(negedge clk);
    excp_flush = r_excp; eentry = r_eentry;
    ertn_flush = r_ertn; era = r_era;
    br_taken = r_br; br_target = r_br_target;
    ds_allowin = r_allow;
    inst_sram_addr_ok = ($urandom_range(0, 99) < addr_pct);
    if (mem_addr_q.size() != 0 && mem_cyc_q[0] < cyc && !mem_hold &&
        $urandom_range(0, 99) < data_pct) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata = mem_word(mem_addr_q[0]);
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata = $urandom;
    end
    #1;
    redir = r_excp | r_ertn | r_br;
    last_req = inst_sram_req;
    if (redir) begin
      check("valid_on_redirect", 65'(fs_to_ds_valid), 65'(0));
      check("req_on_redirect", 65'(inst_sram_req), 65'(0));
    end
    if (exp_mis) check("req_halted", 65'(inst_sram_req), 65'(0));
    if (inst_sram_req) begin
      check("req_addr", 65'(inst_sram_addr), 65'(exp_req_pc));
      check("inflight_bound", 65'(mem_addr_q.size() < MAX_OUT), 65'(1));
    end
    if (exp_mis && exp_adef_done && !redir)
      check("valid_after_adef", 65'(fs_to_ds_valid), 65'(0));
    else if (fs_to_ds_valid && ds_allowin && !redir) begin
      exp_bus = exp_mis ? {exp_pc, 32'h0, 1'b1} : {exp_pc, mem_word(exp_pc), 1'b0};
      check("deliver", fs_to_ds_bus, exp_bus);
      n_deliv++; deliv_cyc.push_back(cyc); deliv_pc.push_back(fs_to_ds_bus[64:33]);
      if (exp_mis) exp_adef_done = 1'b1;
      else exp_pc = exp_pc + 32'd4;
    end
    if (inst_sram_req && inst_sram_addr_ok) begin
      mem_addr_q.push_back(inst_sram_addr); mem_cyc_q.push_back(cyc);
      n_hs++;
      exp_req_pc = exp_req_pc + 32'd4;
    end
    if (inst_sram_data_ok) begin
      void'(mem_addr_q.pop_front()); void'(mem_cyc_q.pop_front());
    end
    if (redir) begin
      if (r_excp)      tgt = r_eentry;
      else if (r_ertn) tgt = r_era;
      else             tgt = r_br_target;
      exp_pc = tgt; exp_req_pc = tgt; exp_mis = (tgt[1:0] != 2'b00); exp_adef_done = 1'b0;
    end
    r_excp = 1'b0; r_ertn = 1'b0; r_br = 1'b0;
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    reset = 1'b1;
    ds_allowin = 1'b0; excp_flush = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0;
    eentry = '0; era = '0; br_target = '0;
    inst_sram_addr_ok = 1'b0; inst_sram_data_ok = 1'b0; inst_sram_rdata = '0;
    r_eentry = '0; r_era = '0; r_br_target = '0;
    mem_hold = 1'b0; addr_pct = 100; data_pct = 100;

    // Sustained one-per-cycle delivery from reset.
    do_reset();
    r_allow = 1'b1; deliv_cyc.delete(); n_deliv = 0;
    repeat (8) step();
    check("sustain_count", 65'(n_deliv), 65'(6));
    if (deliv_cyc.size() >= 3)
      check("sustain_spacing", 65'(deliv_cyc[2] - deliv_cyc[0]), 65'(2));

    // Decode stalled: fill exactly IQ_DEPTH then stop requesting.
    do_reset();
    r_allow = 1'b0; n_hs = 0;
    repeat (20) step();
    check("stall_handshakes", 65'(n_hs), 65'(IQ_DEPTH));
    check("stall_req_low", 65'(last_req), 65'(0));
    check("stall_none_inflight", 65'(mem_addr_q.size()), 65'(0));
    r_allow = 1'b1; n_deliv = 0;
    repeat (12) step();
    check("stall_drain", 65'(n_deliv >= IQ_DEPTH), 65'(1));

    // Two outstanding then branch: both responses dropped.
    do_reset();
    r_allow = 1'b1; mem_hold = 1'b1; n_hs = 0;
    repeat (4) step();
    check("two_outstanding", 65'(n_hs), 65'(2));
    r_br = 1'b1; r_br_target = 32'h1c000100;
    step();
    mem_hold = 1'b0; deliv_pc.delete();
    repeat (12) step();
    check("br_first_pc", 65'(deliv_pc.size() != 0 ? deliv_pc[0] : 32'hx), 65'(32'h1c000100));

    // Exception wins over branch.
    r_excp = 1'b1; r_eentry = 32'h1c008000; r_br = 1'b1; r_br_target = 32'h1c000100;
    step();
    deliv_pc.delete();
    repeat (10) step();
    check("excp_priority", 65'(deliv_pc.size() != 0 ? deliv_pc[0] : 32'hx), 65'(32'h1c008000));

    // Misaligned branch target: one adef entry, then silence until ertn.
    r_br = 1'b1; r_br_target = 32'h1c000102;
    step();
    n_hs = 0; deliv_pc.delete();
    repeat (10) step();
    check("adef_no_requests", 65'(n_hs), 65'(0));
    check("adef_one_entry", 65'(deliv_pc.size()), 65'(1));
    r_ertn = 1'b1; r_era = 32'h1c000040;
    step();
    deliv_pc.delete();
    repeat (10) step();
    check("ertn_first_pc", 65'(deliv_pc.size() != 0 ? deliv_pc[0] : 32'hx), 65'(32'h1c000040));

    // Redirect landing on a data_ok cycle in steady flow.
    r_br = 1'b1; r_br_target = 32'h1c000200;
    step();
    deliv_pc.delete();
    repeat (10) step();
    check("coincident_first_pc", 65'(deliv_pc.size() != 0 ? deliv_pc[0] : 32'hx), 65'(32'h1c000200));

    // Random traffic with redirects, stalls and a mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        addr_pct = $urandom_range(30, 100);
        data_pct = $urandom_range(30, 100);
      end
      if (i == 1500) do_reset();
      r_allow = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        sel = 3'($urandom_range(1, 7));
        r_excp = sel[2]; r_ertn = sel[1]; r_br = sel[0];
        r_eentry = rand_target(); r_era = rand_target(); r_br_target = rand_target();
      end
      step();
    end

    // Forward progress after the random phase.
    addr_pct = 100; data_pct = 100; r_allow = 1'b1;
    r_br = 1'b1; r_br_target = 32'h1c001000;
    step();
    n_deliv = 0;
    repeat (20) step();
    check("liveness", 65'(n_deliv >= 10), 65'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
